// File: rtl/mem_dispatcher__read_lines.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_dispatcher__read_lines
// Reads num_lines lines of words_per_line words through one controller read
// port, in bursts of at most MAX_BURST words, and streams them to a buffer.
// Rev 1.0
// ============================================================================
module mem_dispatcher__read_lines #(
   parameter int DATA_W         = 32,
   parameter int MAX_BURST      = 64,
   parameter int CNT_W          = 16,
   parameter int LINES_W        = 10,
   parameter int BUFF_ADDR_BITS = 11
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mem_calib_done,
   input  logic                      start,
   input  logic [29:0]               start_addr,
   input  logic [CNT_W-1:0]          words_per_line,
   input  logic [LINES_W-1:0]        num_lines,
   input  logic [29:0]               line_stride,
   output logic                      busy,
   output logic                      done,
   output logic                      data_out__we,
   output logic [BUFF_ADDR_BITS-1:0] data_out__addr,
   output logic [LINES_W-1:0]        data_out__line,
   output logic [DATA_W-1:0]         data_out,
   output logic                      port_cmd_en,
   output logic [2:0]                port_cmd_instr,
   output logic [5:0]                port_cmd_bl,
   output logic [29:0]               port_cmd_byte_addr,
   input  logic                      port_cmd_full,
   output logic                      port_rd_en,
   input  logic [DATA_W-1:0]         port_rd_data,
   input  logic                      port_rd_empty
);

   localparam int                    BYTES       = DATA_W / 8;
   localparam int                    BYTE_SHIFT  = $clog2(BYTES);
   localparam logic [CNT_W-1:0]      MAX_BURST_C = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0]      ONE_CNT     = CNT_W'(1);
   localparam logic [LINES_W:0]      ONE_LINE    = (LINES_W + 1)'(1);
   localparam logic [BUFF_ADDR_BITS-1:0] ONE_IDX = BUFF_ADDR_BITS'(1);
   localparam logic [2:0]            INSTR_READ  = 3'b001;

   typedef enum logic [2:0] {
      S_WAIT_CALIB = 3'd0,
      S_IDLE       = 3'd1,
      S_CMD        = 3'd2,
      S_DRAIN      = 3'd3,
      S_FIN        = 3'd4
   } state_t;

   state_t                    state_q,      state_d;
   logic [CNT_W-1:0]          wpl_q,        wpl_d;
   logic [LINES_W-1:0]        nlines_q,     nlines_d;
   logic [29:0]               stride_q,     stride_d;
   logic [LINES_W-1:0]        line_q,       line_d;
   logic [CNT_W-1:0]          rem_q,        rem_d;
   logic [29:0]               line_base_q,  line_base_d;
   logic [29:0]               burst_addr_q, burst_addr_d;
   logic [5:0]                cmd_bl_q,     cmd_bl_d;
   logic [6:0]                beats_q,      beats_d;
   logic [6:0]                beat_cnt_q,   beat_cnt_d;
   logic [BUFF_ADDR_BITS-1:0] word_idx_q,   word_idx_d;
   logic                      we_q,         we_d;
   logic [BUFF_ADDR_BITS-1:0] out_addr_q,   out_addr_d;
   logic [LINES_W-1:0]        out_line_q,   out_line_d;
   logic [DATA_W-1:0]         out_data_q,   out_data_d;

   logic                      pop;
   logic                      last_beat;
   logic                      more_lines;
   logic [29:0]               next_line_base;

   // Burst length field for a given number of remaining words (caller ensures r > 0).
   function automatic logic [5:0] burst_bl(input logic [CNT_W-1:0] r);
      if (r >= MAX_BURST_C) begin
         return 6'(MAX_BURST - 1);
      end
      return 6'(r - ONE_CNT);
   endfunction

   assign pop            = (state_q == S_DRAIN) && !port_rd_empty;
   assign last_beat      = (beat_cnt_q + 7'd1) == beats_q;
   assign more_lines     = ({1'b0, line_q} + ONE_LINE) < {1'b0, nlines_q};
   assign next_line_base = line_base_q + stride_q;

   always_comb begin
      state_d      = state_q;
      wpl_d        = wpl_q;
      nlines_d     = nlines_q;
      stride_d     = stride_q;
      line_d       = line_q;
      rem_d        = rem_q;
      line_base_d  = line_base_q;
      burst_addr_d = burst_addr_q;
      cmd_bl_d     = cmd_bl_q;
      beats_d      = beats_q;
      beat_cnt_d   = beat_cnt_q;
      word_idx_d   = word_idx_q;
      we_d         = 1'b0;
      out_addr_d   = out_addr_q;
      out_line_d   = out_line_q;
      out_data_d   = out_data_q;

      case (state_q)
         S_WAIT_CALIB: begin
            if (mem_calib_done) begin
               state_d = S_IDLE;
            end
         end

         S_IDLE: begin
            if (start) begin
               if ((words_per_line == '0) || (num_lines == '0)) begin
                  state_d = S_FIN;
               end else begin
                  wpl_d        = words_per_line;
                  nlines_d     = num_lines;
                  stride_d     = line_stride;
                  line_d       = '0;
                  rem_d        = words_per_line;
                  line_base_d  = start_addr;
                  burst_addr_d = start_addr;
                  cmd_bl_d     = burst_bl(words_per_line);
                  word_idx_d   = '0;
                  state_d      = S_CMD;
               end
            end
         end

         S_CMD: begin
            if (!port_cmd_full) begin
               beats_d    = {1'b0, cmd_bl_q} + 7'd1;
               beat_cnt_d = '0;
               state_d    = S_DRAIN;
            end
         end

         S_DRAIN: begin
            if (pop) begin
               we_d       = 1'b1;
               out_data_d = port_rd_data;
               out_addr_d = word_idx_q;
               out_line_d = line_q;
               word_idx_d = word_idx_q + ONE_IDX;
               rem_d      = rem_q - ONE_CNT;
               beat_cnt_d = beat_cnt_q + 7'd1;
               if (last_beat) begin
                  // rem_q still counts the word popped this cycle
                  if (rem_q != ONE_CNT) begin
                     burst_addr_d = burst_addr_q + (30'(beats_q) << BYTE_SHIFT);
                     cmd_bl_d     = burst_bl(rem_q - ONE_CNT);
                     state_d      = S_CMD;
                  end else if (more_lines) begin
                     line_d       = line_q + LINES_W'(1);
                     line_base_d  = next_line_base;
                     burst_addr_d = next_line_base;
                     rem_d        = wpl_q;
                     cmd_bl_d     = burst_bl(wpl_q);
                     word_idx_d   = '0;
                     state_d      = S_CMD;
                  end else begin
                     state_d      = S_FIN;
                  end
               end
            end
         end

         S_FIN: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_WAIT_CALIB;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_WAIT_CALIB;
         wpl_q        <= '0;
         nlines_q     <= '0;
         stride_q     <= '0;
         line_q       <= '0;
         rem_q        <= '0;
         line_base_q  <= '0;
         burst_addr_q <= '0;
         cmd_bl_q     <= '0;
         beats_q      <= '0;
         beat_cnt_q   <= '0;
         word_idx_q   <= '0;
         we_q         <= 1'b0;
         out_addr_q   <= '0;
         out_line_q   <= '0;
         out_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         wpl_q        <= wpl_d;
         nlines_q     <= nlines_d;
         stride_q     <= stride_d;
         line_q       <= line_d;
         rem_q        <= rem_d;
         line_base_q  <= line_base_d;
         burst_addr_q <= burst_addr_d;
         cmd_bl_q     <= cmd_bl_d;
         beats_q      <= beats_d;
         beat_cnt_q   <= beat_cnt_d;
         word_idx_q   <= word_idx_d;
         we_q         <= we_d;
         out_addr_q   <= out_addr_d;
         out_line_q   <= out_line_d;
         out_data_q   <= out_data_d;
      end
   end

   // Status outputs are pure decodes of the registered state.
   assign busy               = (state_q == S_WAIT_CALIB) || (state_q == S_CMD) ||
                               (state_q == S_DRAIN);
   assign done               = (state_q == S_FIN);
   assign port_cmd_en        = (state_q == S_CMD) && !port_cmd_full;
   assign port_cmd_instr     = INSTR_READ;
   assign port_cmd_bl        = cmd_bl_q;
   assign port_cmd_byte_addr = burst_addr_q;
   assign port_rd_en         = pop;
   assign data_out__we       = we_q;
   assign data_out__addr     = out_addr_q;
   assign data_out__line     = out_line_q;
   assign data_out           = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_dispatcher__read_lines.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mem_dispatcher__read_lines
// Drives a read-port controller model and checks commands and buffer writes.
// Rev 1.0
// ============================================================================
module tb_mem_dispatcher__read_lines;

   localparam int DATA_W    = 32;
   localparam int MAX_BURST = 64;
   localparam int CNT_W     = 16;
   localparam int LINES_W   = 10;
   localparam int BAB       = 11;
   localparam int BYTES     = DATA_W / 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              mem_calib_done;
   logic              start;
   logic [29:0]       start_addr;
   logic [CNT_W-1:0]  words_per_line;
   logic [LINES_W-1:0] num_lines;
   logic [29:0]       line_stride;
   logic              busy, done;
   logic              data_out__we;
   logic [BAB-1:0]    data_out__addr;
   logic [LINES_W-1:0] data_out__line;
   logic [DATA_W-1:0] data_out;
   logic              port_cmd_en;
   logic [2:0]        port_cmd_instr;
   logic [5:0]        port_cmd_bl;
   logic [29:0]       port_cmd_byte_addr;
   logic              port_cmd_full;
   logic              port_rd_en;
   logic [DATA_W-1:0] port_rd_data;
   logic              port_rd_empty;

   mem_dispatcher__read_lines #(
      .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W),
      .LINES_W(LINES_W), .BUFF_ADDR_BITS(BAB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mem_calib_done(mem_calib_done), .start(start),
      .start_addr(start_addr), .words_per_line(words_per_line), .num_lines(num_lines),
      .line_stride(line_stride), .busy(busy), .done(done),
      .data_out__we(data_out__we), .data_out__addr(data_out__addr),
      .data_out__line(data_out__line), .data_out(data_out),
      .port_cmd_en(port_cmd_en), .port_cmd_instr(port_cmd_instr), .port_cmd_bl(port_cmd_bl),
      .port_cmd_byte_addr(port_cmd_byte_addr), .port_cmd_full(port_cmd_full),
      .port_rd_en(port_rd_en), .port_rd_data(port_rd_data), .port_rd_empty(port_rd_empty)
   );

   initial forever #5 clk = ~clk;

   typedef struct { logic [5:0] bl; logic [29:0] addr; } cmd_t;
   typedef struct { logic [31:0] data; logic [BAB-1:0] addr; logic [LINES_W-1:0] line; } word_t;
   typedef struct {
      logic [29:0] sa; int wpl; int nl; logic [29:0] stride;
      bit stall; int bubble; int ncmd; int nwords;
   } vec_t;

   cmd_t        exp_cmds[$];
   word_t       exp_words[$];
   logic [31:0] rdq[$];

   int tests = 0, fails = 0;
   int cmds_seen = 0, words_seen = 0, done_seen = 0;
   int bubble_pct = 0, stall_left = 0;
   bit stall_en = 0, stall_used = 0, pending_stall = 0;

   // Memory contents as seen by the controller model: a hash of the byte address.
   function automatic logic [31:0] mem_word(input logic [29:0] a);
      return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected commands and words derived directly from the line/burst rules.
   task automatic build_exp(input logic [29:0] sa, input int wpl, input int nl,
                            input logic [29:0] stride);
      cmd_t  c;
      word_t w;
      logic [29:0] base, nn;
      exp_cmds.delete();
      exp_words.delete();
      for (int n = 0; n < nl; n++) begin
         nn   = 30'(n);
         base = sa + nn * stride;
         for (int off = 0; off < wpl; off += MAX_BURST) begin
            c.bl   = 6'(((wpl - off) < MAX_BURST ? (wpl - off) : MAX_BURST) - 1);
            c.addr = base + 30'(off * BYTES);
            exp_cmds.push_back(c);
         end
         for (int k = 0; k < wpl; k++) begin
            w.data = mem_word(base + 30'(k * BYTES));
            w.addr = BAB'(k);
            w.line = LINES_W'(n);
            exp_words.push_back(w);
         end
      end
   endtask

   // Controller model: command FIFO back-pressure, read FIFO with bubbles, output monitor.
   initial begin
      cmd_t  c;
      word_t w;
      port_cmd_full = 1'b0;
      port_rd_empty = 1'b1;
      port_rd_data  = '0;
      forever begin
         @(negedge clk);
         if (pending_stall && rdq.size() == 0) begin
            stall_left    = 10;
            pending_stall = 0;
         end
         port_cmd_full = (stall_left > 0);
         if (stall_left > 0) stall_left--;
         port_rd_empty = (rdq.size() == 0) || ($urandom_range(0, 99) < bubble_pct);
         port_rd_data  = (rdq.size() != 0) ? rdq[0] : $urandom;
         #1;
         if (rst_n) begin
            if (port_cmd_full) check("cmd_en_while_full", port_cmd_en, 0);
            if (port_cmd_en) begin
               check("cmd_instr", port_cmd_instr, 3'b001);
               check("one_outstanding", rdq.size(), 0);
               if (exp_cmds.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_cmd: got bl=%0d addr=%0h expected none",
                           port_cmd_bl, port_cmd_byte_addr);
               end else begin
                  c = exp_cmds.pop_front();
                  check("cmd_bl", port_cmd_bl, c.bl);
                  check("cmd_addr", port_cmd_byte_addr, c.addr);
               end
               for (int i = 0; i <= int'(port_cmd_bl); i++)
                  rdq.push_back(mem_word(port_cmd_byte_addr + 30'(i * BYTES)));
               cmds_seen++;
               if (stall_en && !stall_used) begin
                  pending_stall = 1;
                  stall_used    = 1;
               end
            end
            if (port_rd_en) begin
               if (port_rd_empty) begin
                  tests++; fails++;
                  $display("FAIL rd_en_on_empty: got rd_en=1 expected 0");
               end
               if (rdq.size() != 0) void'(rdq.pop_front());
            end
            if (data_out__we) begin
               words_seen++;
               if (exp_words.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_write: got addr=%0d line=%0d expected none",
                           data_out__addr, data_out__line);
               end else begin
                  w = exp_words.pop_front();
                  check("wr_data", data_out, w.data);
                  check("wr_addr", data_out__addr, w.addr);
                  check("wr_line", data_out__line, w.line);
               end
            end
            if (done) done_seen++;
         end
      end
   end

   task automatic run_xfer(input logic [29:0] sa, input int wpl, input int nl,
                           input logic [29:0] stride, input bit stall, input int bubble,
                           input int ncmd, input int nwords);
      int c0, w0, d0, cyc, budget, want_c, want_w;
      bit got;
      build_exp(sa, wpl, nl, stride);
      want_c = (ncmd >= 0) ? ncmd : exp_cmds.size();
      want_w = (nwords >= 0) ? nwords : exp_words.size();
      stall_en = stall; stall_used = 0; pending_stall = 0; bubble_pct = bubble;
      c0 = cmds_seen; w0 = words_seen; d0 = done_seen;
      budget = wpl * nl * 3 + 200;
      @(negedge clk);
      start_addr = sa; words_per_line = CNT_W'(wpl); num_lines = LINES_W'(nl);
      line_stride = stride; start = 1'b1;
      cyc = 0; got = 0;
      while (!got && cyc < budget) begin
         @(negedge clk);
         start = 1'b0;
         #2;
         cyc++;
         if (cyc == 1 && wpl != 0 && nl != 0) check("busy_after_start", busy, 1);
         if (done_seen > d0) got = 1;
      end
      if (!got) begin
         tests++; fails++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
      end else begin
         check("busy_with_done", busy, 0);
         if (wpl == 0 || nl == 0) check("zero_size_done_latency_le2", (cyc <= 2), 1);
      end
      repeat (3) @(negedge clk);
      #2;
      check("done_pulses", done_seen - d0, 1);
      check("cmd_count", cmds_seen - c0, want_c);
      check("word_count", words_seen - w0, want_w);
      check("leftover_cmds", exp_cmds.size(), 0);
      check("leftover_words", exp_words.size(), 0);
      check("busy_idle", busy, 0);
      exp_cmds.delete(); exp_words.delete(); rdq.delete();
      stall_en = 0; bubble_pct = 0;
   endtask

   task automatic check_reset_values();
      check("rst_busy", busy, 1);
      check("rst_done", done, 0);
      check("rst_cmd_en", port_cmd_en, 0);
      check("rst_rd_en", port_rd_en, 0);
      check("rst_we", data_out__we, 0);
      check("rst_addr", data_out__addr, 0);
      check("rst_line", data_out__line, 0);
      check("rst_bl", port_cmd_bl, 0);
      check("rst_byte_addr", port_cmd_byte_addr, 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no completion expected summary before 900us");
      $fatal(1, "watchdog");
   end

   vec_t vecs[12];

   initial begin
      int c0, w0, busy_low, bound;
      vecs[0]  = '{30'h1000,     150,  1, 30'h0,        0,  0,  3,  150};
      vecs[1]  = '{30'h0,         64,  3, 30'h4000,     0,  0,  3,  192};
      vecs[2]  = '{30'h200,      100,  2, 30'h1000,     1,  0,  4,  200};
      vecs[3]  = '{30'h40,        70,  2, 30'h800,      0, 30,  4,  140};
      vecs[4]  = '{30'h0,          0,  5, 30'h100,      0,  0,  0,    0};
      vecs[5]  = '{30'h10,         5,  0, 30'h20,       0,  0,  0,    0};
      vecs[6]  = '{30'h3FFFFFF0,  10,  3, 30'h3FFFFFF8, 0,  0,  3,   30};
      vecs[7]  = '{30'h0,       2100,  1, 30'h0,        0, 10, 33, 2100};
      vecs[8]  = '{30'h8,          1,  4, 30'h20,       1,  0,  4,    4};
      vecs[9]  = '{30'h100,       64,  1, 30'h0,        0,  0,  1,   64};
      vecs[10] = '{30'h100,       65,  1, 30'h0,        0, 25,  2,   65};
      vecs[11] = '{30'h0,        128,  2, 30'h0,        0,  0,  4,  256};

      rst_n = 1'b0; mem_calib_done = 1'b0; start = 1'b0;
      start_addr = '0; words_per_line = '0; num_lines = '0; line_stride = '0;
      repeat (3) @(negedge clk);
      #2;
      check_reset_values();

      // Uncalibrated: start must be ignored and busy held high.
      rst_n = 1'b1;
      busy_low = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         start = (i == 5); words_per_line = 16'd10; num_lines = 10'd1;
         #2;
         if (!busy) busy_low++;
      end
      start = 1'b0;
      check("uncalib_busy_low_cycles", busy_low, 0);
      check("uncalib_cmds", cmds_seen, 0);
      @(negedge clk);
      mem_calib_done = 1'b1;
      @(negedge clk);
      #2;
      check("calib_to_idle_busy", busy, 0);

      for (int v = 0; v < 12; v++)
         run_xfer(vecs[v].sa, vecs[v].wpl, vecs[v].nl, vecs[v].stride,
                  vecs[v].stall, vecs[v].bubble, vecs[v].ncmd, vecs[v].nwords);

      for (int r = 0; r < 6; r++)
         run_xfer(30'($urandom), $urandom_range(1, 180), $urandom_range(1, 3),
                  30'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 40), -1, -1);

      // Reset in the middle of a burst, with an ignored start while busy.
      build_exp(30'h1000, 150, 1, 30'h0);
      c0 = cmds_seen; w0 = words_seen;
      @(negedge clk);
      start_addr = 30'h1000; words_per_line = 16'd150; num_lines = 10'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      bound = 0;
      while (words_seen < w0 + 10 && bound < 300) begin @(negedge clk); bound++; end
      start_addr = 30'h2000; words_per_line = 16'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (words_seen < w0 + 40 && bound < 300) begin @(negedge clk); bound++; end
      check("mid_drain_reached", (words_seen >= w0 + 40), 1);
      check("ignored_start_cmds", cmds_seen - c0, 1);
      rst_n = 1'b0;
      @(negedge clk);
      #2;
      check_reset_values();
      rst_n = 1'b1;
      rdq.delete(); exp_cmds.delete(); exp_words.delete();
      pending_stall = 0; stall_left = 0;
      repeat (2) @(negedge clk);
      run_xfer(30'h30, 20, 2, 30'h100, 0, 20, 2, 40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
